instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_pkg.sv | 21 ++
 rtl/instr_fetch_ctrl_if.sv | 23 ++
 rtl/instr_fetch_fifo.sv | 71 +++++++
 rtl/instr_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h3000;

  function automatic logic [15:0] next_pc(input logic [15:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Instruction memory bus plus decode-side buffer head, bundled for the fetch controller.
interface instr_fetch_ctrl_if;

  logic [15:0] PC;
  logic        instrmem_rd;
  logic [15:0] instr_dout;
  logic        complete_instr;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;

  modport master (
    output PC, instrmem_rd, ir, ir_pc, ir_valid,
    input  instr_dout, complete_instr, ir_ready
  );

  modport slave (
    input  PC, instrmem_rd, ir, ir_pc, ir_valid,
    output instr_dout, complete_instr, ir_ready
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Small instruction buffer (DEPTH entries, 1..4) with push, pop and flush; flush wins.
module instr_fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic [2:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = bump(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = bump(rd_ptr_q);
      end
      count_d = count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: one outstanding request, branch redirect/drop, small buffer.
// Define INSTR_FETCH_PERF_CNT_EN to add saturating fetch_cnt/drop_cnt outputs.
module instr_fetch_ctrl
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable_fetch,
  input  logic                br_taken,
  input  logic [15:0]         taddr_pc,
  instr_fetch_ctrl_if.master  bus
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [15:0]         fetch_cnt,
  output logic [15:0]         drop_cnt
`endif
);

  localparam logic [2:0] DEPTH_C = 3'(BUF_DEPTH);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         rd_q, rd_d;
  logic         push, pop, flush;
  logic         fetch_done, resp_dropped;
  logic [2:0]   count;
  logic [2:0]   count_after_push;
  fetch_entry_t head;

  // A redirect kills the buffer, so a same-cycle pop must not advance it.
  assign flush            = br_taken;
  assign pop              = (count != 3'd0) && bus.ir_ready && !br_taken;
  assign count_after_push = count + 3'd1 - {2'b00, pop};

  instr_fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry ('{pc: pc_q, instr: bus.instr_dout}),
    .head       (head),
    .count      (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!br_taken && enable_fetch && (count < DEPTH_C)) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (br_taken) begin
          state_d = bus.complete_instr ? ST_IDLE : ST_DROP;
        end else if (bus.complete_instr) begin
          state_d = (enable_fetch && (count_after_push < DEPTH_C)) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (bus.complete_instr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    rd_d         = (state_d == ST_REQ);
    push         = 1'b0;
    fetch_done   = 1'b0;
    resp_dropped = 1'b0;
    if (br_taken) begin
      pc_d = taddr_pc;
    end else if ((state_q == ST_REQ) && bus.complete_instr) begin
      push       = 1'b1;
      fetch_done = 1'b1;
      pc_d       = next_pc(pc_q);
    end
    if (bus.complete_instr &&
        ((state_q == ST_DROP) || ((state_q == ST_REQ) && br_taken))) begin
      resp_dropped = 1'b1;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.instrmem_rd = rd_q;
  assign bus.ir_valid    = (count != 3'd0);
  assign bus.ir          = (count != 3'd0) ? head.instr : 16'h0000;
  assign bus.ir_pc       = (count != 3'd0) ? head.pc : 16'h0000;

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (fetch_done && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (resp_dropped && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = fetch_done ^ resp_dropped;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl (BUF_DEPTH=2, RESET_PC=16'h3000), one edge per vector.
module tb_instr_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic        enable_fetch;
  logic        br_taken;
  logic [15:0] taddr_pc;
  int          vec_count;
  int          miss_count;

  instr_fetch_ctrl_if bus_if ();

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] drop_cnt;
`endif

  instr_fetch_ctrl #(
    .RESET_PC  (16'h3000),
    .BUF_DEPTH (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable_fetch (enable_fetch),
    .br_taken     (br_taken),
    .taddr_pc     (taddr_pc),
    .bus          (bus_if.master)
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change on the falling edge; outputs are read at the next falling edge.
  task automatic applyStimulus(input logic en, input logic br, input logic [15:0] taddr,
                               input logic comp, input logic [15:0] dout, input logic rdy);
    enable_fetch          = en;
    br_taken              = br;
    taddr_pc              = taddr;
    bus_if.complete_instr = comp;
    bus_if.instr_dout     = dout;
    bus_if.ir_ready       = rdy;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    reset      = 1'b1;
    @(negedge clock);
    doReset();

    checkOutput("reset_pc", bus_if.PC, 16'h3000);
    checkOutput("reset_rd", 16'(bus_if.instrmem_rd), 16'h0);
    checkOutput("reset_valid", 16'(bus_if.ir_valid), 16'h0);
    checkOutput("reset_ir", bus_if.ir, 16'h0000);
    checkOutput("reset_ir_pc", bus_if.ir_pc, 16'h0000);

    $display("[TB] streaming fetch");
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s1_rd", 16'(bus_if.instrmem_rd), 16'h1);
    checkOutput("s1_pc0", bus_if.PC, 16'h3000);
    checkOutput("s1_valid_before", 16'(bus_if.ir_valid), 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 16'hA001, 1'b1);
    checkOutput("s1_valid", 16'(bus_if.ir_valid), 16'h1);
    checkOutput("s1_ir0", bus_if.ir, 16'hA001);
    checkOutput("s1_irpc0", bus_if.ir_pc, 16'h3000);
    checkOutput("s1_pc1", bus_if.PC, 16'h3001);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 16'hA002, 1'b1);
    checkOutput("s1_ir1", bus_if.ir, 16'hA002);
    checkOutput("s1_irpc1", bus_if.ir_pc, 16'h3001);
    checkOutput("s1_pc2", bus_if.PC, 16'h3002);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'hA003, 1'b1);
    checkOutput("s1_irpc2", bus_if.ir_pc, 16'h3002);
    checkOutput("s1_rd_off", 16'(bus_if.instrmem_rd), 16'h0);
    checkOutput("s1_pc3", bus_if.PC, 16'h3003);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s1_drained", 16'(bus_if.ir_valid), 16'h0);

    $display("[TB] buffer full with decode stalled");
    doReset();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 16'hB000, 1'b0);
    checkOutput("s2_pc1", bus_if.PC, 16'h3001);
    checkOutput("s2_rd_still", 16'(bus_if.instrmem_rd), 16'h1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 16'hB001, 1'b0);
    checkOutput("s2_rd_full", 16'(bus_if.instrmem_rd), 16'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0);
      checkOutput("s2_rd_hold", 16'(bus_if.instrmem_rd), 16'h0);
      checkOutput("s2_irpc_hold", bus_if.ir_pc, 16'h3000);
      checkOutput("s2_ir_hold", bus_if.ir, 16'hB000);
      checkOutput("s2_pc_hold", bus_if.PC, 16'h3002);
    end
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b1);
    checkOutput("s2_pop_irpc", bus_if.ir_pc, 16'h3001);
    checkOutput("s2_pop_ir", bus_if.ir, 16'hB001);
    checkOutput("s2_pop_rd", 16'(bus_if.instrmem_rd), 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0);
    checkOutput("s2_refetch_rd", 16'(bus_if.instrmem_rd), 16'h1);
    checkOutput("s2_refetch_pc", bus_if.PC, 16'h3002);

    $display("[TB] branch while request pending");
    applyStimulus(1'b1, 1'b1, 16'h4100, 1'b0, 16'h0000, 1'b1);
    checkOutput("s3_flush_valid", 16'(bus_if.ir_valid), 16'h0);
    checkOutput("s3_drop_rd", 16'(bus_if.instrmem_rd), 16'h0);
    checkOutput("s3_pc_tgt", bus_if.PC, 16'h4100);
    applyStimulus(1'b1, 1'b1, 16'h4000, 1'b0, 16'h0000, 1'b0);
    checkOutput("s3_drop_rebr_pc", bus_if.PC, 16'h4000);
    checkOutput("s3_drop_rebr_rd", 16'(bus_if.instrmem_rd), 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0);
    checkOutput("s3_drop_wait_rd", 16'(bus_if.instrmem_rd), 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 16'hDEAD, 1'b0);
    checkOutput("s3_stale_valid", 16'(bus_if.ir_valid), 16'h0);
    checkOutput("s3_stale_ir", bus_if.ir, 16'h0000);
    checkOutput("s3_after_drop_pc", bus_if.PC, 16'h4000);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0);
    checkOutput("s3_new_rd", 16'(bus_if.instrmem_rd), 16'h1);
    checkOutput("s3_new_pc", bus_if.PC, 16'h4000);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'hC000, 1'b0);
    checkOutput("s3_new_ir", bus_if.ir, 16'hC000);
    checkOutput("s3_new_irpc", bus_if.ir_pc, 16'h4000);
    checkOutput("s3_pc_inc", bus_if.PC, 16'h4001);

    $display("[TB] branch coincident with response");
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0);
    checkOutput("s4_rd", 16'(bus_if.instrmem_rd), 16'h1);
    checkOutput("s4_pc", bus_if.PC, 16'h4001);
    applyStimulus(1'b1, 1'b1, 16'h5000, 1'b1, 16'hEEEE, 1'b0);
    checkOutput("s4_flush_valid", 16'(bus_if.ir_valid), 16'h0);
    checkOutput("s4_pc_tgt", bus_if.PC, 16'h5000);
    checkOutput("s4_rd_off", 16'(bus_if.instrmem_rd), 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0);
    checkOutput("s4_no_drop_rd", 16'(bus_if.instrmem_rd), 16'h1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'hF000, 1'b0);
    checkOutput("s4_ir", bus_if.ir, 16'hF000);
    checkOutput("s4_irpc", bus_if.ir_pc, 16'h5000);

    $display("[TB] PC wrap");
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    checkOutput("s5_flush_valid", 16'(bus_if.ir_valid), 16'h0);
    checkOutput("s5_pc_tgt", bus_if.PC, 16'hFFFF);
    checkOutput("s5_br_blocks_rd", 16'(bus_if.instrmem_rd), 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0);
    checkOutput("s5_rd", 16'(bus_if.instrmem_rd), 16'h1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'h1234, 1'b0);
    checkOutput("s5_pc_wrap", bus_if.PC, 16'h0000);
    checkOutput("s5_irpc", bus_if.ir_pc, 16'hFFFF);
    checkOutput("s5_ir", bus_if.ir, 16'h1234);

    $display("[TB] reset mid-request");
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0);
    checkOutput("s6_rd", 16'(bus_if.instrmem_rd), 16'h1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b0);
    reset = 1'b0;
    checkOutput("s6_rst_pc", bus_if.PC, 16'h3000);
    checkOutput("s6_rst_rd", 16'(bus_if.instrmem_rd), 16'h0);
    checkOutput("s6_rst_valid", 16'(bus_if.ir_valid), 16'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 16'h9999, 1'b0);
    checkOutput("s6_late_valid", 16'(bus_if.ir_valid), 16'h0);
    checkOutput("s6_late_pc", bus_if.PC, 16'h3000);

`ifdef INSTR_FETCH_PERF_CNT_EN
    $display("[TB] performance counters");
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 16'h7000, 1'b1);
    end
    applyStimulus(1'b1, 1'b1, 16'h6000, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 16'h0BAD, 1'b1);
    checkOutput("s7_fetch_cnt", fetch_cnt, 16'd5);
    checkOutput("s7_drop_cnt", drop_cnt, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
